instr_decode_queue: RTL and testbench
=====================================

# instr_decode_queue

Parametrised instruction queue with registered pre-decode, sitting between the fetch stage and the decode/issue stage of the MIPS pipeline. Each fetched word is classified into one instruction class and tagged reserved-instruction (RI) at enqueue time. Class and RI flag are stored alongside PC and instruction, so decode reads them straight from a register. Supports valid/ready handshakes on both sides, synchronous flush on branch/exception redirect, and build-time disabling of optional instruction groups.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- PC_W, 32, PC width
- EN_COP0, 1, 0 → eret/mfc0/mtc0 decode as RI
- EN_EXT, 1, 0 → ins/ext/lwl/lwr decode as RI
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear
- in_valid  in  1  fetch offers a word
- in_ready  out  1  queue can accept a word
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- out_class  out  4  head class code
- out_ri  out  1  head is reserved instruction
- count  out  log2(DEPTH)+1  occupancy

## Operation
- Class codes:
  - 0 NOP: word == 0
  - 1 ALU_R: op 0; funct add/addu/sub/subu/and/or/xor/nor/slt/sltu
  - 2 ALU_I: addi/addiu/andi/ori/xori/slti/sltiu/lui
  - 3 SHIFT: op 0; funct sll (nonzero word)/srl/sra/sllv/srlv/srav
  - 4 BRANCH: beq/bne/blez/bgtz; op 1 with rt 00000/00001/10000
  - 5 JUMP: j/jal; op 0 with funct jr/jalr
  - 6 LOAD: lw/lh/lhu/lb/lbu, plus lwl/lwr when EN_EXT
  - 7 STORE: sw/sh/sb
  - 8 MULDIV: mult/multu/div/divu
  - 9 HILO: mfhi/mflo/mthi/mtlo
  - 10 BITFIELD: op 011111 with funct 000100 (ins) or 000000 (ext), when EN_EXT
  - 11 COP0, when EN_COP0:
    - eret: op 010000, funct 011000
    - mfc0: op 010000, rs 00000, bits[10:0] 0
    - mtc0: op 010000, rs 00100, bits[10:0] 0
  - 15 RESERVED: anything else; out_ri=1 iff class 15
- Encodings are standard MIPS32.
- Push: in_valid && in_ready at the edge → word, PC and decoded class are written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready at the edge → rd_ptr increments mod DEPTH.
- in_ready = (count < DEPTH) && !flush. No pass-through: a simultaneous pop does not free a slot in the same cycle.
- out_valid = (count != 0). out_* is driven combinationally from the rd_ptr slot.
- Simultaneous push and pop: count unchanged, both pointers advance.
- flush: at the edge, count and both pointers go to 0. A push or pop in the same cycle is discarded. flush has priority over everything except reset.
- Reset (async assert, sync release):
  - pointers and count go to 0
  - storage is cleared to 0
  - out_valid=0, in_ready=1
  - out_instr=0, out_pc=0, out_class=0, out_ri=0
- Reset mid-transfer drops all entries; nothing is replayed.
- When out_valid=0, the out_* data fields are don't-care for consumers, but must equal storage contents (never X after reset).

## Timing
- Enqueue-to-head latency is 1 cycle: a word pushed into an empty queue at edge N has out_valid=1 after edge N.
- Throughput: 1 push and 1 pop per cycle sustained while 0 < count < DEPTH.
- Full: count==DEPTH, in_ready=0. A pop at edge N re-asserts in_ready after edge N.
- Pointers wrap DEPTH-1 → 0 with no bubble.
- in_ready and out_valid depend only on registered state and flush. There are no combinational paths from in_valid or out_ready.

## Test plan
- Reset with queue populated: assert reset_n=0 mid-cycle → immediately count=0, out_valid=0, in_ready=1, out_class=0; after release, first push 0x00000000 → out_class=0 (NOP), out_ri=0.
- Fill/drain DEPTH=4:
  - stimulus: push 0x02328021 (addu), 0x3C01ABCD (lui), 0x8C220004 (lw), 0x1000FFFF (beq); out_ready=0
  - response: count=4, in_ready=0
  - then drain: classes pop as 1, 2, 6, 4 in order with matching PCs, and in_ready=1 after the first pop.
- Wrap-around: stream 10 words with out_ready=1 continuously → one word out per cycle in order, PCs preserved, count never exceeds 1.
- Reserved/optional instructions:
  - EN_COP0=0: push 0x42000018 (eret) → class 15, out_ri=1
  - EN_COP0=1: same word → class 11, out_ri=0
  - push 0xFC000000 → class 15 in either configuration
- Flush: with 3 entries queued, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, and the pushed word is never observed.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 → pop occurs, push is refused (in_ready=0 that cycle), count=3 next cycle.

Source files
------------

// File: rtl/instr_decode_queue.sv
// Instruction queue with registered pre-decode between fetch and decode/issue.
// Each accepted word is classified and tagged reserved-instruction at enqueue,
// so decode reads class and RI flag straight from storage with no decode logic
// on its path.
module instr_decode_queue #(
   parameter int DEPTH   = 4,     // power of two, >= 2
   parameter int PC_W    = 32,
   parameter bit EN_COP0 = 1'b1,  // 0: eret/mfc0/mtc0 decode as reserved
   parameter bit EN_EXT  = 1'b1   // 0: ins/ext/lwl/lwr decode as reserved
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [3:0]               out_class,
   output logic                     out_ri,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   localparam logic [3:0] CLS_NOP    = 4'd0;
   localparam logic [3:0] CLS_ALU_R  = 4'd1;
   localparam logic [3:0] CLS_ALU_I  = 4'd2;
   localparam logic [3:0] CLS_SHIFT  = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_JUMP   = 4'd5;
   localparam logic [3:0] CLS_LOAD   = 4'd6;
   localparam logic [3:0] CLS_STORE  = 4'd7;
   localparam logic [3:0] CLS_MULDIV = 4'd8;
   localparam logic [3:0] CLS_HILO   = 4'd9;
   localparam logic [3:0] CLS_BITFLD = 4'd10;
   localparam logic [3:0] CLS_COP0   = 4'd11;
   localparam logic [3:0] CLS_RSV    = 4'd15;

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [31:0]     mem_instr_q [DEPTH];
   logic [PC_W-1:0] mem_pc_q    [DEPTH];
   logic [3:0]      mem_class_q [DEPTH];
   logic            mem_ri_q    [DEPTH];

   logic [3:0] dec_class;
   logic       push, pop;

   wire [5:0] op    = in_instr[31:26];
   wire [4:0] rs    = in_instr[25:21];
   wire [4:0] rt    = in_instr[20:16];
   wire [5:0] funct = in_instr[5:0];

   // Ready/valid come only from registered state and flush.
   assign in_ready  = (count_q != DEPTH_C) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;
   assign count     = count_q;

   assign out_instr = mem_instr_q[rd_ptr_q];
   assign out_pc    = mem_pc_q[rd_ptr_q];
   assign out_class = mem_class_q[rd_ptr_q];
   assign out_ri    = mem_ri_q[rd_ptr_q];

   // Classify the incoming word; anything unmatched stays reserved.
   always_comb begin
      dec_class = CLS_RSV;
      case (op)
         6'h00: begin
            if (in_instr == 32'd0) dec_class = CLS_NOP;
            else begin
               case (funct)
                  6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                  6'h26, 6'h27, 6'h2A, 6'h2B:              dec_class = CLS_ALU_R;
                  6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_class = CLS_SHIFT;
                  6'h08, 6'h09:                             dec_class = CLS_JUMP;
                  6'h18, 6'h19, 6'h1A, 6'h1B:               dec_class = CLS_MULDIV;
                  6'h10, 6'h11, 6'h12, 6'h13:               dec_class = CLS_HILO;
                  default:                                  dec_class = CLS_RSV;
               endcase
            end
         end
         6'h01: if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10) dec_class = CLS_BRANCH;
         6'h02, 6'h03:                             dec_class = CLS_JUMP;
         6'h04, 6'h05, 6'h06, 6'h07:               dec_class = CLS_BRANCH;
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F:               dec_class = CLS_ALU_I;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25:        dec_class = CLS_LOAD;
         6'h22, 6'h26: if (EN_EXT)                 dec_class = CLS_LOAD;
         6'h28, 6'h29, 6'h2B:                      dec_class = CLS_STORE;
         6'h1F: if (EN_EXT && (funct == 6'h04 || funct == 6'h00)) dec_class = CLS_BITFLD;
         6'h10: begin
            if (EN_COP0) begin
               if (funct == 6'h18)                                   dec_class = CLS_COP0;
               else if ((rs == 5'h00 || rs == 5'h04) && in_instr[10:0] == 11'd0)
                                                                     dec_class = CLS_COP0;
            end
         end
         default: dec_class = CLS_RSV;
      endcase
   end

   // Pointer and occupancy next state; flush overrides push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // One storage slot per entry, cleared on reset so outputs are never X.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Capture word, PC and pre-decode when this slot is the write target.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            mem_instr_q[gi] <= '0;
            mem_pc_q[gi]    <= '0;
            mem_class_q[gi] <= '0;
            mem_ri_q[gi]    <= 1'b0;
         end else if (push && wr_ptr_q == AW'(gi)) begin
            mem_instr_q[gi] <= in_instr;
            mem_pc_q[gi]    <= in_pc;
            mem_class_q[gi] <= dec_class;
            mem_ri_q[gi]    <= (dec_class == CLS_RSV);
         end
      end
   end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench: two queue instances (optional groups on / off) share one
// stimulus stream; a scoreboard of expected head entries is checked each cycle.
module tb_instr_decode_queue;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic        in_ready, out_valid, out_ri;
   logic [31:0] out_instr, out_pc;
   logic [3:0]  out_class;
   logic [2:0]  count;
   logic        o0_in_ready, o0_out_valid, o0_out_ri;
   logic [31:0] o0_out_instr, o0_out_pc;
   logic [3:0]  o0_out_class;
   logic [2:0]  o0_count;

   always #5 clk = ~clk;

   instr_decode_queue #(.DEPTH(4), .PC_W(32), .EN_COP0(1'b1), .EN_EXT(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_class(out_class), .out_ri(out_ri), .count(count));

   instr_decode_queue #(.DEPTH(4), .PC_W(32), .EN_COP0(1'b0), .EN_EXT(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(o0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(o0_out_valid), .out_ready(out_ready), .out_instr(o0_out_instr),
      .out_pc(o0_out_pc), .out_class(o0_out_class), .out_ri(o0_out_ri), .count(o0_count));

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  c1;   // expected class with optional groups enabled
      logic [3:0]  c0;   // expected class with optional groups disabled
   } sb_t;

   sb_t sb[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   // Word table with hand-derived class for both configurations.
   logic [31:0] wtab [16];
   logic [3:0]  ctab1 [16];
   logic [3:0]  ctab0 [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock: drive inputs, check head/handshake against the scoreboard,
   // clock, update the scoreboard, check occupancy.
   task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic [3:0] c1, input logic [3:0] c0,
                        input logic rdy, input logic fl);
      logic psh, pp;
      sb_t  e;
      in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
      #1;
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (sb.size() < 4) && !fl});
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() != 0) begin
         chk("out_instr", out_instr, sb[0].instr);
         chk("out_pc",    out_pc,    sb[0].pc);
         chk("out_class", {28'd0, out_class}, {28'd0, sb[0].c1});
         chk("out_ri",    {31'd0, out_ri},    {31'd0, sb[0].c1 == 4'd15});
         chk("o0_class",  {28'd0, o0_out_class}, {28'd0, sb[0].c0});
         chk("o0_ri",     {31'd0, o0_out_ri},    {31'd0, sb[0].c0 == 4'd15});
      end
      psh = v && (sb.size() < 4) && !fl;
      pp  = rdy && (sb.size() != 0) && !fl;
      $display("cycle: v=%0b instr=%h pc=%h rdy=%0b flush=%0b push=%0b pop=%0b",
               v, w, pc, rdy, fl, psh, pp);
      @(posedge clk);
      #1;
      if (fl) sb.delete();
      else begin
         if (pp) void'(sb.pop_front());
         if (psh) begin
            e.instr = w; e.pc = pc; e.c1 = c1; e.c0 = c0;
            sb.push_back(e);
         end
      end
      chk("count", {29'd0, count}, sb.size());
   endtask

   task automatic push_idx(input int i, input logic [31:0] pc, input logic rdy);
      cycle(1'b1, wtab[i], pc, ctab1[i], ctab0[i], rdy, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 32'h0, 32'h0, 4'd0, 4'd0, rdy, 1'b0);
   endtask

   initial begin
      wtab[0]  = 32'h00000000; ctab1[0]  = 4'd0;  ctab0[0]  = 4'd0;   // nop
      wtab[1]  = 32'h02328021; ctab1[1]  = 4'd1;  ctab0[1]  = 4'd1;   // addu
      wtab[2]  = 32'h3C01ABCD; ctab1[2]  = 4'd2;  ctab0[2]  = 4'd2;   // lui
      wtab[3]  = 32'h8C220004; ctab1[3]  = 4'd6;  ctab0[3]  = 4'd6;   // lw
      wtab[4]  = 32'h1000FFFF; ctab1[4]  = 4'd4;  ctab0[4]  = 4'd4;   // beq
      wtab[5]  = 32'h00021080; ctab1[5]  = 4'd3;  ctab0[5]  = 4'd3;   // sll
      wtab[6]  = 32'h08000010; ctab1[6]  = 4'd5;  ctab0[6]  = 4'd5;   // j
      wtab[7]  = 32'hAC220004; ctab1[7]  = 4'd7;  ctab0[7]  = 4'd7;   // sw
      wtab[8]  = 32'h0043001A; ctab1[8]  = 4'd8;  ctab0[8]  = 4'd8;   // div
      wtab[9]  = 32'h00001010; ctab1[9]  = 4'd9;  ctab0[9]  = 4'd9;   // mfhi
      wtab[10] = 32'h7C0A2004; ctab1[10] = 4'd10; ctab0[10] = 4'd15;  // ins
      wtab[11] = 32'h88220000; ctab1[11] = 4'd6;  ctab0[11] = 4'd15;  // lwl
      wtab[12] = 32'h42000018; ctab1[12] = 4'd11; ctab0[12] = 4'd15;  // eret
      wtab[13] = 32'h40026000; ctab1[13] = 4'd11; ctab0[13] = 4'd15;  // mfc0
      wtab[14] = 32'hFC000000; ctab1[14] = 4'd15; ctab0[14] = 4'd15;  // reserved op
      wtab[15] = 32'h04020000; ctab1[15] = 4'd15; ctab0[15] = 4'd15;  // regimm rt=2

      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      @(posedge clk); #1;
      chk("rst_count",     {29'd0, count},     32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc",    out_pc,    32'd0);
      chk("rst_out_class", {28'd0, out_class}, 32'd0);
      chk("rst_out_ri",    {31'd0, out_ri},    32'd0);
      reset_n = 1'b1;

      // Fill to DEPTH with the decode stalled, then drain.
      push_idx(1, 32'h00400000, 1'b0);
      push_idx(2, 32'h00400004, 1'b0);
      push_idx(3, 32'h00400008, 1'b0);
      push_idx(4, 32'h0040000C, 1'b0);
      push_idx(5, 32'h00400010, 1'b0);   // refused: queue full
      repeat (4) idle(1'b1);
      idle(1'b1);

      // Stream 10 words through with the consumer always ready (wraps pointers).
      for (int i = 0; i < 10; i++) push_idx(i + 5 < 16 ? i + 5 : i, 32'h00500000 + 32'(i * 4), 1'b1);
      idle(1'b1);

      // Optional groups and reserved encodings, both configurations.
      push_idx(12, 32'h00600000, 1'b0);
      push_idx(14, 32'h00600004, 1'b0);
      push_idx(13, 32'h00600008, 1'b0);
      push_idx(15, 32'h0060000C, 1'b0);
      repeat (4) idle(1'b1);
      push_idx(10, 32'h00600010, 1'b1);
      push_idx(11, 32'h00600014, 1'b1);
      idle(1'b1);

      // Flush with 3 queued while pushing and popping: everything discarded.
      push_idx(1, 32'h00700000, 1'b0);
      push_idx(2, 32'h00700004, 1'b0);
      push_idx(3, 32'h00700008, 1'b0);
      cycle(1'b1, wtab[4], 32'h0070000C, ctab1[4], ctab0[4], 1'b1, 1'b1);
      push_idx(7, 32'h00700010, 1'b0);   // head must be this word, not the flushed one
      idle(1'b1);

      // Full with simultaneous pop: pop happens, push refused.
      push_idx(6, 32'h00800000, 1'b0);
      push_idx(7, 32'h00800004, 1'b0);
      push_idx(8, 32'h00800008, 1'b0);
      push_idx(9, 32'h0080000C, 1'b0);
      push_idx(1, 32'h00800010, 1'b1);
      repeat (3) idle(1'b1);

      // Asynchronous reset with entries queued, observed before any clock edge.
      push_idx(2, 32'h00900000, 1'b0);
      push_idx(3, 32'h00900004, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("arst_count",     {29'd0, count},     32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("arst_out_class", {28'd0, out_class}, 32'd0);
      chk("arst_out_instr", out_instr, 32'd0);
      sb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      push_idx(0, 32'h00A00000, 1'b0);   // NOP after reset
      idle(1'b1);
      idle(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
